adder_mp_serial: RTL
====================

Name: adder_mp_serial

Overview:
- Parametrised multi-precision adder/subtractor that processes one LIMB_W-bit limb per clock, least-significant limb first, with a registered 1-bit carry chained between limbs.
- Operands are N_LIMBS*LIMB_W bits wide and are captured on a start handshake.
- Reports busy while running, a one-cycle done pulse on completion, and the final carry-out.
- Serves as the area-lean wide-arithmetic engine for the FPGA exercises; at the defaults it matches the 400-bit datapath width.

Parameters:
- LIMB_W, 8, width in bits of one limb processed per cycle (>=1).
- N_LIMBS, 50, number of limbs (>=1); total width TW = LIMB_W*N_LIMBS.
- IDX_W, $clog2(N_LIMBS) (min 1), width of the internal limb index counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while idle.
- sub  in  1  0 = a+b, 1 = a-b (two's complement); sampled with start.
- a_flat  in  TW  operand A, limb i at [i*LIMB_W +: LIMB_W]; sampled with start.
- b_flat  in  TW  operand B, same packing; sampled with start.
- sum_flat  out  TW  result, same packing.
- carry_out  out  1  final carry (add: unsigned overflow; sub: 1 = no borrow, A>=B unsigned).
- busy  out  1  high while limbs are being computed.
- done  out  1  one-cycle pulse when sum_flat/carry_out are valid.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; sum_flat=0, carry_out=0, busy=0, done=0; internal carry, index, operand registers cleared. Reset mid-operation aborts; no done is issued.
- FSM states: IDLE, RUN.
- IDLE, start=1 at edge E0:
  - latch a_flat, b_flat, sub;
  - carry <= sub; idx <= 0; sum_flat <= 0; done <= 0;
  - state <= RUN; busy <= 1.
- IDLE, start=0: hold all outputs; done <= 0.
- RUN, each edge:
  - {c, s} = A_i + (B_i XOR {LIMB_W{sub}}) + carry, computed LIMB_W+1 bits wide, with i = idx;
  - sum_flat[idx*LIMB_W +: LIMB_W] <= s; carry <= c; idx <= idx+1.
- RUN, edge processing idx = N_LIMBS-1:
  - carry_out <= c; done <= 1; busy <= 0; state <= IDLE; idx <= 0.
- Latency: start accepted at E0, last limb at edge E(N_LIMBS), done high during the cycle after E(N_LIMBS). Throughput is one operation per N_LIMBS+1 cycles.
- start while busy (RUN) is ignored and not queued. Input changes during RUN have no effect, since operands are latched.
- start high in the done cycle (state IDLE) is accepted; done falls at that same edge.
- sum_flat and carry_out hold their values after done until the next accepted start. Intermediate sum_flat during RUN is partial and must not be consumed.
- No combinational path from inputs to outputs; all outputs are registered.
- N_LIMBS=1: a single RUN cycle, done one cycle after start.

Test Plan:
- Defaults, a=1, b=1, sub=0 -> after 50 cycles done=1 for exactly 1 cycle, sum_flat=2, carry_out=0; busy high for exactly 50 cycles.
- Defaults, a=all ones (2^400-1), b=1, sub=0 -> sum_flat=0, carry_out=1; confirms the carry ripples through all 50 limbs.
- Defaults, a=5, b=7, sub=1 -> sum_flat=2^400-2 (all ones except LSB 0), carry_out=0 (borrow); then a=7, b=5, sub=1 -> sum_flat=2, carry_out=1.
- start re-pulsed at cycles 3 and 20 of a run, with a/b changed mid-run -> result equals the originally latched operands; exactly one done; start asserted in the done cycle launches a second operation with correct result.
- rst asserted at cycle 25 of a run -> next cycle all outputs 0, no done pulse; a subsequent start with a=0x80 (limb0) + b=0x80 -> sum_flat=0x100, carry_out=0.
- LIMB_W=4, N_LIMBS=3 and LIMB_W=16, N_LIMBS=1, with randomized a, b, sub (>=1000 ops each) -> sum_flat/carry_out match the reference model (a ± b mod 2^TW, with carry bit); done latency = N_LIMBS cycles.

Source files
------------

// File: rtl/adder_mp_serial.sv
// Serial multi-precision adder/subtractor: one LIMB_W-bit limb per clock, LS limb first,
// with a registered carry chained between limbs. All outputs are registered.
module adder_mp_serial #(
  parameter int LIMB_W  = 8,
  parameter int N_LIMBS = 50,
  parameter int IDX_W   = (N_LIMBS > 1) ? $clog2(N_LIMBS) : 1,
  localparam int TW     = LIMB_W * N_LIMBS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          sub,
  input  logic [TW-1:0] a_flat,
  input  logic [TW-1:0] b_flat,
  output logic [TW-1:0] sum_flat,
  output logic          carry_out,
  output logic          busy,
  output logic          done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LIMBS - 1);

  logic [0:0]                     state_r;
  logic [N_LIMBS-1:0][LIMB_W-1:0] a_r;
  logic [N_LIMBS-1:0][LIMB_W-1:0] b_r;
  logic [N_LIMBS-1:0][LIMB_W-1:0] sum_r;
  logic                           sub_r;
  logic                           carry_r;
  logic [IDX_W-1:0]               idx_r;

  logic [LIMB_W-1:0] a_limb_s;
  logic [LIMB_W-1:0] b_limb_s;
  logic [LIMB_W-1:0] limb_sum_s;
  logic              limb_carry_s;

  // Subtraction is A + ~B + 1: the carry register is seeded with sub at start.
  always_comb begin
    a_limb_s = a_r[idx_r];
    b_limb_s = b_r[idx_r] ^ {LIMB_W{sub_r}};
    {limb_carry_s, limb_sum_s} = {1'b0, a_limb_s} + {1'b0, b_limb_s}
                               + {{LIMB_W{1'b0}}, carry_r};
  end

  assign sum_flat = sum_r;

  // Control FSM and limb datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      sum_r     <= '0;
      sub_r     <= 1'b0;
      carry_r   <= 1'b0;
      idx_r     <= '0;
      carry_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r     <= a_flat;
            b_r     <= b_flat;
            sub_r   <= sub;
            carry_r <= sub;
            idx_r   <= '0;
            sum_r   <= '0;
            busy    <= 1'b1;
            state_r <= RUN;
          end
        end
        RUN: begin
          sum_r[idx_r] <= limb_sum_s;
          carry_r      <= limb_carry_s;
          if (idx_r == LAST_IDX) begin
            carry_out <= limb_carry_s;
            done      <= 1'b1;
            busy      <= 1'b0;
            idx_r     <= '0;
            state_r   <= IDLE;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
